stopwatch_cu: RTL and testbench

Control unit for the stopwatch datapath: turns raw board buttons into debounced single-cycle commands and sequences the counter.
- Runs the STOP / RUN / CLEAR state machine.
- Drives run-enable and clear strobes into the stopwatch counter chain, plus a synchronized display-select to the FND controller.
- Sits between the board pins (btnL_RunStop, btnR_Clear, sw0) and the time-counter datapath inside the stopwatch top.

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/stopwatch_cu.sv | 93 +++++++++
 tb/tb_stopwatch_cu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and constants for the stopwatch control unit
//
// Purpose : Holds the state typedef, the state width, the default debounce
//           length, and the next-state function used by stopwatch_cu.
// Contents: STATE_W, DEBOUNCE_CYC_DEFAULT, sw_state_t (ST_STOP/ST_RUN/ST_CLEAR),
//           next_state().
package stopwatch_pkg;

   localparam int STATE_W              = 2;
   localparam int DEBOUNCE_CYC_DEFAULT = 100_000;

   typedef enum logic [STATE_W-1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10
   } sw_state_t;

   // Clear wins over run/stop when both pulses arrive together in STOP.
   // In RUN a clear pulse never changes state; the lap option only toggles a flag.
   // The unused 2'b11 code falls into default and recovers to STOP.
   function automatic sw_state_t next_state(input sw_state_t cur,
                                            input logic      run_p,
                                            input logic      clr_p);
      sw_state_t nxt;
      nxt = ST_STOP;
      case (cur)
         ST_STOP: begin
            if (clr_p)      nxt = ST_CLEAR;
            else if (run_p) nxt = ST_RUN;
            else            nxt = ST_STOP;
         end
         ST_RUN:   nxt = run_p ? ST_STOP : ST_RUN;
         ST_CLEAR: nxt = ST_STOP;
         default:  nxt = ST_STOP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce counter and rising-edge pulse
//
// Purpose : Brings a raw asynchronous button into the clk domain, accepts a
//           level change only after DEBOUNCE_CYC consecutive differing samples,
//           and emits a one-cycle pulse on each accepted press.
// Ports   : clk   - system clock
//           reset - asynchronous, active-high reset
//           btn   - raw button level
//           pulse - registered one-cycle pulse per accepted rising level
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 100_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             s1;
   logic             s2;
   logic             db_level;
   logic             db_prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         cnt      <= '0;
         pulse    <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;

         // Any sample that agrees with the accepted level restarts the count,
         // so only an unbroken run of DEBOUNCE_CYC differing samples flips it.
         if (s2 == db_level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db_level <= s2;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         db_prev <= db_level;
         pulse   <= db_level & ~db_prev;
      end
   end

endmodule

// File: rtl/stopwatch_cu.sv
// rtl/stopwatch_cu.sv - stopwatch control unit: debounced buttons and STOP/RUN/CLEAR FSM
//
// Purpose : Turns raw board buttons into single-cycle commands, sequences the
//           stopwatch counter and passes a synchronized display select through.
// Options : STOPWATCH_LAP_EN - when defined, a clear press in RUN toggles o_lap.
// Ports   : clk, reset             - clock, asynchronous active-high reset
//           btnL_RunStop           - raw run/stop button
//           btnR_Clear             - raw clear button
//           sw0                    - raw display-mode switch
//           o_run                  - counter run enable (state == RUN)
//           o_clear                - counter clear strobe (state == CLEAR)
//           o_disp_sel             - sw0 after a 2-FF synchronizer
//           o_lap                  - display-freeze flag
//           o_state                - current state encoding
module stopwatch_cu
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btnL_RunStop,
   input  logic               btnR_Clear,
   input  logic               sw0,
   output logic               o_run,
   output logic               o_clear,
   output logic               o_disp_sel,
   output logic               o_lap,
   output logic [STATE_W-1:0] o_state
);

   logic      run_pulse;
   logic      clr_pulse;
   logic      sw_s1;
   sw_state_t state;
   sw_state_t state_nxt;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_run (
      .clk   (clk),
      .reset (reset),
      .btn   (btnL_RunStop),
      .pulse (run_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
      .clk   (clk),
      .reset (reset),
      .btn   (btnR_Clear),
      .pulse (clr_pulse)
   );

   // Display select is a level switch, so a plain synchronizer is enough.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_s1      <= 1'b0;
         o_disp_sel <= 1'b0;
      end else begin
         sw_s1      <= sw0;
         o_disp_sel <= sw_s1;
      end
   end

   assign state_nxt = next_state(state, run_pulse, clr_pulse);
   assign o_state   = state;

   // Outputs are registered from the same next-state value as the state
   // register, so they always equal a decode of the current state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_STOP;
         o_run   <= 1'b0;
         o_clear <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         o_lap   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         o_run   <= (state_nxt == ST_RUN);
         o_clear <= (state_nxt == ST_CLEAR);
`ifdef STOPWATCH_LAP_EN
         if (state_nxt != ST_RUN)
            o_lap <= 1'b0;
         else if (state == ST_RUN && clr_pulse)
            o_lap <= ~o_lap;
`endif
      end
   end

`ifndef STOPWATCH_LAP_EN
   assign o_lap = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_cu.sv
// tb/tb_stopwatch_cu.sv - self-checking bench for stopwatch_cu
module tb_stopwatch_cu;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btnL_RunStop = 1'b0;
   logic       btnR_Clear = 1'b0;
   logic       sw0 = 1'b0;
   logic       o_run;
   logic       o_clear;
   logic       o_disp_sel;
   logic       o_lap;
   logic [1:0] o_state;

   int checks = 0;
   int errors = 0;

   stopwatch_cu #(.DEBOUNCE_CYC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .btnL_RunStop (btnL_RunStop),
      .btnR_Clear   (btnR_Clear),
      .sw0          (sw0),
      .o_run        (o_run),
      .o_clear      (o_clear),
      .o_disp_sel   (o_disp_sel),
      .o_lap        (o_lap),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   // kind: 0 = run/stop button, 1 = clear button, 2 = both together
   typedef struct {
      string      name;
      int         kind;
      int         len;
      logic       exp_run;
      logic       exp_lap;
      logic [1:0] exp_state;
      int         exp_clr_cycles;
      int         exp_run_toggles;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Press for len cycles, release, let everything settle; count clear-high
   // cycles and o_run transitions seen at the falling edges.
   task automatic press(input int kind, input int len,
                        output int clr_cycles, output int run_toggles);
      logic prev_run;
      clr_cycles  = 0;
      run_toggles = 0;
      @(negedge clk);
      prev_run = o_run;
      btnL_RunStop = (kind == 0 || kind == 2);
      btnR_Clear   = (kind == 1 || kind == 2);
      for (int i = 0; i < len + 16; i++) begin
         @(negedge clk);
         if (o_clear) clr_cycles++;
         if (o_run != prev_run) run_toggles++;
         prev_run = o_run;
         if (i == len - 1) begin
            btnL_RunStop = 1'b0;
            btnR_Clear   = 1'b0;
         end
      end
   endtask

   initial begin
      int clr_c;
      int tog_c;
      int busy;
      int first_rise;

      vecs[0] = '{"run_start",   0, 10, 1'b1, 1'b0, 2'b01, 0, 1};
      vecs[1] = '{"run_stop",    0, 10, 1'b0, 1'b0, 2'b00, 0, 1};
      vecs[2] = '{"glitch",      0,  3, 1'b0, 1'b0, 2'b00, 0, 0};
      vecs[3] = '{"clear_stop",  1, 10, 1'b0, 1'b0, 2'b00, 1, 0};
      vecs[4] = '{"run_again",   0, 10, 1'b1, 1'b0, 2'b01, 0, 1};
`ifdef STOPWATCH_LAP_EN
      vecs[5] = '{"clear_in_run",1, 10, 1'b1, 1'b1, 2'b01, 0, 0};
`else
      vecs[5] = '{"clear_in_run",1, 10, 1'b1, 1'b0, 2'b01, 0, 0};
`endif
      vecs[6] = '{"stop_again",  0, 10, 1'b0, 1'b0, 2'b00, 0, 1};
      vecs[7] = '{"both_in_stop",2, 10, 1'b0, 1'b0, 2'b00, 1, 0};

      // Reset
      #20 reset = 1'b0;
      @(negedge clk);
      check("rst_run",   o_run,   0);
      check("rst_clear", o_clear, 0);
      check("rst_lap",   o_lap,   0);
      check("rst_state", o_state, 0);
      check("rst_disp",  o_disp_sel, 0);
      busy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_run || o_clear || o_lap || o_state != 2'b00) busy++;
      end
      check("idle_activity", busy, 0);

      // Display-select synchronizer: two edges of latency
      @(negedge clk);
      sw0 = 1'b1;
      @(posedge clk); #1;
      check("disp_sel_e0", o_disp_sel, 0);
      @(posedge clk); #1;
      check("disp_sel_e1", o_disp_sel, 1);
      @(negedge clk);
      sw0 = 1'b0;

      // Table-driven presses
      for (int v = 0; v < 8; v++) begin
         press(vecs[v].kind, vecs[v].len, clr_c, tog_c);
         check({vecs[v].name, "_run"},     o_run,   vecs[v].exp_run);
         check({vecs[v].name, "_lap"},     o_lap,   vecs[v].exp_lap);
         check({vecs[v].name, "_state"},   o_state, vecs[v].exp_state);
         check({vecs[v].name, "_clr_cyc"}, clr_c,   vecs[v].exp_clr_cycles);
         check({vecs[v].name, "_run_tog"}, tog_c,   vecs[v].exp_run_toggles);
      end

      // Exact latency: o_run rises on edge E0+7
      @(negedge clk);
      btnL_RunStop = 1'b1;
      @(posedge clk);
      first_rise = -1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (first_rise < 0 && o_run) first_rise = i;
         if (i == 9) btnL_RunStop = 1'b0;
      end
      check("latency_edges", first_rise, 7);
      repeat (10) @(negedge clk);
      check("latency_state", o_state, 1);

      // Async reset mid-RUN, off the clock edge
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("async_rst_run",   o_run,   0);
      check("async_rst_state", o_state, 0);
      #2 reset = 1'b0;

      // Button held through reset release must re-qualify
      @(negedge clk);
      btnL_RunStop = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #3 reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i == 7) check("requal_before", o_run, 0);
         if (i == 8) check("requal_after",  o_run, 1);
      end
      btnL_RunStop = 1'b0;
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
